sseg_port_display: RTL

- Port-mapped output peripheral for the RAT MCU system. Sits downstream of the MCU output bus, beside the LED register, and consumes OUT_PORT/PORT_ID/IO_STRB writes.
- Holds a 16-bit value and drives a 4-digit common-anode seven-segment display as time-multiplexed hexadecimal digits.
- Supports atomic two-byte update, leading-zero blanking and per-digit decimal points.

---
 rtl/sseg_port_display.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sseg_port_display.sv
// Port-mapped 4-digit common-anode seven-segment display for the RAT MCU output bus.
// Holds a 16-bit value committed atomically by a low/high byte pair and scans it out as hex digits.
module sseg_port_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter logic [7:0]  LO_ID       = 8'h81,
  parameter logic [7:0]  HI_ID       = 8'h82,
  parameter logic [7:0]  CTRL_ID     = 8'h83
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] SEGMENTS,
  output logic [3:0] DISP_EN
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(REFRESH_DIV - 1);
  localparam logic [7:0] CTRL_RST = 8'h02;

  logic [7:0]    shadow_lo_q, shadow_lo_d;
  logic [15:0]   disp_val_q,  disp_val_d;
  logic [7:0]    ctrl_q,      ctrl_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic [1:0]    idx_q,       idx_d;
  logic [7:0]    seg_q,       seg_d;
  logic [3:0]    an_q,        an_d;

  logic [3:0]    nibble_s;
  logic [3:0]    dp_mask_s;
  logic          dp_s;
  logic [3:0]    blank_s;

  // Hex nibble to active-low g..a pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Port write decode; the high byte write is the only path that changes the displayed value.
  always_comb begin
    shadow_lo_d = shadow_lo_q;
    disp_val_d  = disp_val_q;
    ctrl_d      = ctrl_q;
    if (IO_STRB) begin
      case (PORT_ID)
        LO_ID:   shadow_lo_d = OUT_PORT;
        HI_ID:   disp_val_d  = {OUT_PORT, shadow_lo_q};
        CTRL_ID: ctrl_d      = OUT_PORT;
        default: ctrl_d      = ctrl_q;
      endcase
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Slot timer and digit index; free-running regardless of the enable bit.
  always_comb begin
    if (cnt_q == CNT_TC) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
      idx_d = idx_q;
    end
  end

  // Digit selection, leading-zero blanking and decimal point for the current slot.
  always_comb begin
    case (idx_q)
      2'd0:    nibble_s = disp_val_q[3:0];
      2'd1:    nibble_s = disp_val_q[7:4];
      2'd2:    nibble_s = disp_val_q[11:8];
      2'd3:    nibble_s = disp_val_q[15:12];
      default: nibble_s = 4'h0;
    endcase
    dp_mask_s  = ctrl_q[7:4];
    dp_s       = dp_mask_s[idx_q];
    blank_s[0] = 1'b0;
    blank_s[1] = ctrl_q[0] && (disp_val_q[15:4]  == 12'h000);
    blank_s[2] = ctrl_q[0] && (disp_val_q[15:8]  == 8'h00);
    blank_s[3] = ctrl_q[0] && (disp_val_q[15:12] == 4'h0);
    if (!ctrl_q[1]) begin
      seg_d = 8'hFF;
      an_d  = 4'b1111;
    end else if (blank_s[idx_q]) begin
      seg_d = {~dp_s, 7'h7F};
      an_d  = ~(4'b0001 << idx_q);
    end else begin
      seg_d = {~dp_s, hex_to_seg(nibble_s)};
      an_d  = ~(4'b0001 << idx_q);
    end
  end

  // State and registered display outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shadow_lo_q <= 8'h00;
      disp_val_q  <= 16'h0000;
      ctrl_q      <= CTRL_RST;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      seg_q       <= 8'hFF;
      an_q        <= 4'b1111;
    end else begin
      shadow_lo_q <= shadow_lo_d;
      disp_val_q  <= disp_val_d;
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign SEGMENTS = seg_q;
  assign DISP_EN  = an_q;

endmodule
